// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - multi-digit BCD up/down counter with run/pause sequencing and 7-segment scan
// Optional leading-zero blanking: define BCD_SCAN_LZB_EN.
module bcd_scan_ctrl #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 10,
   parameter int SCAN_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_syn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  up,
   output logic [4*DIGITS-1:0]   count,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  wrap,
   output logic                  load_err,
   output logic                  running
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t              state, state_nx;
   logic [TW-1:0]       tick, tick_nx;
   logic                do_step;
   logic [4*DIGITS-1:0] load_clean, count_step;
   logic                load_bad, step_wrap, carry;
   logic [SW-1:0]       scan;
   logic [IW-1:0]       idx;
   logic [3:0]          digit_cur;
   logic [7:0]          seg_nx;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0: dec7 = 7'h3F;
         4'd1: dec7 = 7'h06;
         4'd2: dec7 = 7'h5B;
         4'd3: dec7 = 7'h4F;
         4'd4: dec7 = 7'h66;
         4'd5: dec7 = 7'h6D;
         4'd6: dec7 = 7'h7D;
         4'd7: dec7 = 7'h07;
         4'd8: dec7 = 7'h7F;
         4'd9: dec7 = 7'h6F;
         default: dec7 = 7'h00;
      endcase
   endfunction

   // Sequencer: load forces IDLE; ticks only advance while RUN and enabled.
   always_comb begin
      state_nx = state;
      tick_nx  = tick;
      do_step  = 1'b0;
      if (load) begin
         state_nx = IDLE;
         tick_nx  = '0;
      end else begin
         case (state)
            IDLE: begin
               tick_nx = '0;
               if (en) state_nx = RUN;
            end
            RUN: begin
               if (!en) begin
                  state_nx = PAUSE;
               end else if (tick == TICK_LAST) begin
                  tick_nx = '0;
                  do_step = 1'b1;
               end else begin
                  tick_nx = tick + 1'b1;
               end
            end
            PAUSE: if (en) state_nx = RUN;
            default: begin
               state_nx = IDLE;
               tick_nx  = '0;
            end
         endcase
      end
   end

   always_comb begin
      load_clean = load_val;
      load_bad   = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (load_val[4*k +: 4] > 4'd9) begin
            load_clean[4*k +: 4] = 4'd0;
            load_bad             = 1'b1;
         end
      end
   end

   // Ripple carry/borrow; a carry out of the top digit is the full-range wrap.
   always_comb begin
      count_step = count;
      carry      = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (up) begin
               if (count[4*k +: 4] == 4'd9) begin
                  count_step[4*k +: 4] = 4'd0;
               end else begin
                  count_step[4*k +: 4] = count[4*k +: 4] + 4'd1;
                  carry                = 1'b0;
               end
            end else begin
               if (count[4*k +: 4] == 4'd0) begin
                  count_step[4*k +: 4] = 4'd9;
               end else begin
                  count_step[4*k +: 4] = count[4*k +: 4] - 4'd1;
                  carry                = 1'b0;
               end
            end
         end
      end
      step_wrap = carry;
   end

   always_ff @(posedge clk) begin
      if (rst_syn) begin
         state    <= IDLE;
         tick     <= '0;
         count    <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
         running  <= 1'b0;
      end else begin
         state    <= state_nx;
         tick     <= tick_nx;
         running  <= (state_nx == RUN);
         wrap     <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            count    <= load_clean;
            load_err <= load_bad;
         end else if (do_step) begin
            count <= count_step;
            wrap  <= step_wrap;
         end
      end
   end

   assign digit_cur = count[4*idx +: 4];

`ifdef BCD_SCAN_LZB_EN
   logic [DIGITS-1:0] blank_vec;
   logic              hi_zero;

   always_comb begin
      blank_vec = '0;
      hi_zero   = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         hi_zero      = hi_zero & (count[4*k +: 4] == 4'd0);
         blank_vec[k] = hi_zero;
      end
      seg_nx = blank_vec[idx] ? 8'h00 : {1'b0, dec7(digit_cur)};
   end
`else
   always_comb begin
      seg_nx = {1'b0, dec7(digit_cur)};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst_syn) begin
         scan <= '0;
         idx  <= '0;
         seg  <= 8'h00;
         an   <= '1;
      end else begin
         seg <= seg_nx;
         an  <= ~(DIGITS'(1) << idx);
         if (scan == SCAN_LAST) begin
            scan <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            scan <= scan + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - self-checking bench for bcd_scan_ctrl (DIGITS=4, TICK_DIV=2, SCAN_DIV=1)
module tb_bcd_scan_ctrl;

   localparam int D    = 4;
   localparam int TD   = 2;
   localparam int SD   = 1;
   localparam int MAXV = 10000;

   logic          clk = 1'b0;
   logic          rst_syn = 1'b1;
   logic          load = 1'b0;
   logic [15:0]   load_val = '0;
   logic          en = 1'b0;
   logic          up = 1'b1;
   logic [15:0]   count;
   logic [7:0]    seg;
   logic [3:0]    an;
   logic          wrap, load_err, running;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: count held as a plain integer 0..9999
   int         m_state;   // 0 idle, 1 run, 2 pause
   int         m_tick, m_val, m_scan, m_idx;
   logic [7:0] m_seg;
   logic [3:0] m_an;
   logic       m_wrap, m_lerr, m_run;

   typedef struct {
      logic [15:0] lv;
      logic [15:0] exp_cnt;
      logic        exp_err;
   } load_vec_t;
   load_vec_t ltab[6];

   bcd_scan_ctrl #(.DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst_syn(rst_syn), .load(load), .load_val(load_val), .en(en), .up(up),
      .count(count), .seg(seg), .an(an), .wrap(wrap), .load_err(load_err), .running(running)
   );

   always #5 clk = ~clk;

   function automatic int p10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      for (int k = 0; k < D; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
      return r;
   endfunction

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         8: return 8'h7F;  9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_edge();
      logic [3:0] one_hot;
      int         nib;
      if (rst_syn) begin
         m_state = 0; m_tick = 0; m_val = 0; m_scan = 0; m_idx = 0;
         m_seg = 8'h00; m_an = 4'hF; m_wrap = 0; m_lerr = 0; m_run = 0;
         return;
      end
      m_seg = seg_of((m_val / p10(m_idx)) % 10);
`ifdef BCD_SCAN_LZB_EN
      if (m_idx > 0 && (m_val / p10(m_idx)) == 0) m_seg = 8'h00;
`endif
      one_hot = 4'b0001 << m_idx;
      m_an = ~one_hot;
      if (m_scan == SD - 1) begin
         m_scan = 0;
         m_idx  = (m_idx + 1) % D;
      end else begin
         m_scan++;
      end
      m_wrap = 0;
      m_lerr = 0;
      if (load) begin
         m_val = 0;
         for (int k = 0; k < D; k++) begin
            nib = int'(load_val[4*k +: 4]);
            if (nib > 9) m_lerr = 1;
            else m_val += nib * p10(k);
         end
         m_state = 0;
         m_tick  = 0;
      end else if (m_state == 0) begin
         if (en) m_state = 1;
      end else if (m_state == 1) begin
         if (!en) m_state = 2;
         else if (m_tick == TD - 1) begin
            m_tick = 0;
            if (up) begin
               m_wrap = (m_val == MAXV - 1);
               m_val  = (m_val + 1) % MAXV;
            end else begin
               m_wrap = (m_val == 0);
               m_val  = (m_val + MAXV - 1) % MAXV;
            end
         end else begin
            m_tick++;
         end
      end else begin
         if (en) m_state = 1;
      end
      m_run = (m_state == 1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      chk("count", 32'(count), 32'(to_bcd(m_val)));
      chk("seg", 32'(seg), 32'(m_seg));
      chk("an", 32'(an), 32'(m_an));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      chk("load_err", 32'(load_err), 32'(m_lerr));
      chk("running", 32'(running), 32'(m_run));
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1;
      load_val = v;
      cyc();
      load = 1'b0;
   endtask

   task automatic wait_change(input int limit);
      logic [15:0] old;
      int          n;
      old = count;
      n = 0;
      while (count === old && n < limit) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      logic [3:0]  exp_an[5];
      logic [15:0] held;
      logic [7:0]  exp_seg;

      ltab[0] = '{16'h1299, 16'h1299, 1'b0};
      ltab[1] = '{16'h1A3F, 16'h1030, 1'b1};
      ltab[2] = '{16'hFFFF, 16'h0000, 1'b1};
      ltab[3] = '{16'h9999, 16'h9999, 1'b0};
      ltab[4] = '{16'h0042, 16'h0042, 1'b0};
      ltab[5] = '{16'hB000, 16'h0000, 1'b1};
      exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011;
      exp_an[3] = 4'b0111; exp_an[4] = 4'b1110;

      // Reset and scan order
      rst_syn = 1'b1;
      cyc();
      cyc();
      rst_syn = 1'b0;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h00);
      chk("rst_count", 32'(count), 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("scan_an", 32'(an), 32'(exp_an[i]));
         if (i == 0) chk("scan_seg0", 32'(seg), 32'h3F);
      end

      // Load table: sanitising and error pulse
      for (int i = 0; i < 6; i++) begin
         do_load(ltab[i].lv);
         chk("tab_count", 32'(count), 32'(ltab[i].exp_cnt));
         chk("tab_err", 32'(load_err), 32'(ltab[i].exp_err));
         chk("tab_running", 32'(running), 32'h0);
         cyc();
         chk("tab_err_clr", 32'(load_err), 32'h0);
      end

      // Carry across digits
      en = 1'b1; up = 1'b1;
      do_load(16'h1299);
      wait_change(10);
      chk("carry_count", 32'(count), 32'h1300);
      chk("carry_wrap", 32'(wrap), 32'h0);
      chk("carry_running", 32'(running), 32'h1);

      // Up wrap, then down wrap
      do_load(16'h9999);
      wait_change(10);
      chk("wrap_up_count", 32'(count), 32'h0000);
      chk("wrap_up_pulse", 32'(wrap), 32'h1);
      cyc();
      chk("wrap_up_clr", 32'(wrap), 32'h0);
      up = 1'b0;
      do_load(16'h0000);
      wait_change(10);
      chk("wrap_dn_count", 32'(count), 32'h9999);
      chk("wrap_dn_pulse", 32'(wrap), 32'h1);

      // Pause holds count and tick
      cyc();
      en = 1'b0;
      held = count;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("pause_count", 32'(count), 32'(held));
         chk("pause_running", 32'(running), 32'h0);
      end
      en = 1'b1;
      wait_change(10);
      chk("resume_count", 32'(count), 32'(to_bcd(m_val)));

      // Load coinciding with a step edge
      for (int i = 0; i < 10 && !(m_state == 1 && m_tick == TD - 1); i++) cyc();
      do_load(16'h0555);
      chk("load_step_count", 32'(count), 32'h0555);
      chk("load_step_wrap", 32'(wrap), 32'h0);

      // Display of 0042 with and without blanking
      en = 1'b0;
      do_load(16'h0042);
      for (int i = 0; i < 8; i++) begin
         cyc();
         case (an)
`ifdef BCD_SCAN_LZB_EN
            4'b0111, 4'b1011: exp_seg = 8'h00;
`else
            4'b0111, 4'b1011: exp_seg = 8'h3F;
`endif
            4'b1101: exp_seg = 8'h66;
            default: exp_seg = 8'h5B;
         endcase
         if (i > 0) chk("disp_0042", 32'(seg), 32'(exp_seg));
      end

      // Randomised run against the model
      for (int i = 0; i < 3000; i++) begin
         rst_syn = ($urandom_range(0, 299) == 0);
         load    = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0: load_val = 16'h9999;
            1: load_val = 16'h0000;
            default: load_val = 16'($urandom);
         endcase
         en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) up = ~up;
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
